regfile_read_arbiter: RTL



---
 rtl/regfile_read_arbiter_pkg.sv | 15 +
 rtl/regfile_read_arbiter_rr_picker.sv | 39 +++
 rtl/regfile_read_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_pkg.sv
// Shared constants for the register-file read-port arbiter.
// The optional RR_ARB_EN macro (see regfile_read_arbiter.sv) selects round-robin over fixed priority.
package regfile_arb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam int MAX_NREQ = 8;

  // Pointer/index width; a single requester would otherwise give a zero-width field.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping mod NREQ.
// Returns a one-hot grant, its encoded index and an any-grant flag.
module rr_picker
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid requester overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW + 1)'(k);
      if (sum >= (PW + 1)'(NREQ)) sum = sum - (PW + 1)'(NREQ);
      cand = sum[PW-1:0];
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Arbitrates the register file's single read port among NREQ requesters, with write bypass and r0 = 0.
// Define RR_ARB_EN for round-robin; otherwise fixed priority with requester 0 highest.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      rf_raddr,
  input  logic [DW-1:0]      rf_rdata,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  output logic [NREQ-1:0]    resp_valid,
  output logic [DW-1:0]      resp_data
);

  localparam int PW = ptr_width(NREQ);

  // Handshake: a read transfers when req_valid[i] & req_ready[i]; its data arrives the next
  // cycle as resp_valid[i] with resp_data, and must be taken then (no response backpressure).

  logic [NREQ-1:0] req_live;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   pick_ptr;
  logic            pick_any;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   read_value;

  // Reset masks requests so a grant can never be issued while it is high.
  assign req_live = reset ? '0 : req_valid;

`ifdef RR_ARB_EN
  logic [PW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (pick_any) begin
      ptr <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  assign pick_ptr = ptr;
`else
  assign pick_ptr = '0;
`endif

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req   (req_live),
    .ptr   (pick_ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_any && (PW'(i) == pick_idx)) gnt_addr = req_addr[i*AW +: AW];
    end
  end

  assign req_ready = grant;
  assign rf_raddr  = gnt_addr;

  // r0 wins over the bypass: a write to register 0 must never be observed.
  always_comb begin
    if (gnt_addr == AW'(ZERO_REG)) begin
      read_value = '0;
    end else if (wr_en && (wr_addr == gnt_addr)) begin
      read_value = wr_data;
    end else begin
      read_value = rf_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= grant;
      if (pick_any) resp_data <= read_value;
    end
  end

endmodule
